// File: rtl/hilo_mac_sequencer.sv
// hilo_mac_sequencer: radix-2 shift-add MULT/MULTU/MADD/MADDU engine owning HI/LO; optional early exit via HILO_EARLY_TERM_EN; ports clk/rst, start_i/op_i/src_a_i/src_b_i launch, flush_i cancel, mthi/mtlo writes, ready_o/busy_o/done_o status, hi_o/lo_o registers
module hilo_mac_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             mthi_we_i,
  input  logic             mtlo_we_i,
  input  logic [WIDTH-1:0] hi_wdata_i,
  input  logic [WIDTH-1:0] lo_wdata_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_e;
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, a_q, prod;
  logic [WIDTH-1:0]   b_q, hi_q, lo_q, mag_a, mag_b;
  logic [CW-1:0]      count_q;
  logic               sign_q, accum_q, is_signed, calc_last;
  assign is_signed = op_i[0] ^ op_i[1];
  assign mag_a     = (is_signed && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign mag_b     = (is_signed && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  assign prod      = sign_q ? -acc_q : acc_q;
`ifdef HILO_EARLY_TERM_EN
  assign calc_last = (count_q == CW'(1)) || (b_q[WIDTH-1:1] == '0);
`else
  assign calc_last = count_q == CW'(1);
`endif
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb begin
    state_d = (state_q == IDLE) ? (start_i ? CALC : IDLE) :
              (state_q == CALC) ? (flush_i ? IDLE : calc_last ? ACC : CALC) :
              (state_q == ACC)  ? (flush_i ? IDLE : DONE) : IDLE;
  end
  always_comb begin
    ready_o = state_q == IDLE;
    busy_o  = (state_q == CALC) || (state_q == ACC);
    done_o  = state_q == DONE;
  end
  // The multiplicand is kept pre-shifted so each CALC step adds a_q directly.
  always_ff @(posedge clk)
    if (rst) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
      accum_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (state_q == IDLE && start_i) begin
        acc_q   <= '0;
        a_q     <= {{WIDTH{1'b0}}, mag_a};
        b_q     <= mag_b;
        count_q <= CW'(WIDTH);
        sign_q  <= is_signed & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
        accum_q <= op_i[1];
      end
      if (state_q == CALC) begin
        if (b_q[0]) acc_q <= acc_q + a_q;
        a_q     <= a_q << 1;
        b_q     <= b_q >> 1;
        count_q <= count_q - CW'(1);
      end
      if (state_q == IDLE) begin
        if (mthi_we_i) hi_q <= hi_wdata_i;
        if (mtlo_we_i) lo_q <= lo_wdata_i;
      end else if (state_q == ACC && !flush_i)
        {hi_q, lo_q} <= accum_q ? {hi_q, lo_q} + prod : prod;
    end
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule
